// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, issues in-order imem requests and
// buffers the returned words in a DEPTH-entry queue presented to ID.

module if_fetch_entry #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_flush,
    input  logic            i_alloc,
    input  logic [XLEN-1:0] i_alloc_pc,
    input  logic            i_fill,
    input  logic [XLEN-1:0] i_fill_data,
    input  logic            i_deq,
    output logic [XLEN-1:0] o_pc,
    output logic [XLEN-1:0] o_instr,
    output logic            o_filled
);
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_instr;
    logic            r_filled;

    // Alloc, fill and dequeue never target the same entry in one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc     <= '0;
            r_instr  <= '0;
            r_filled <= 1'b0;
        end else if (i_flush) begin
            r_filled <= 1'b0;
        end else begin
            if (i_alloc) begin
                r_pc     <= i_alloc_pc;
                r_filled <= 1'b0;
            end
            if (i_fill) begin
                r_instr  <= i_fill_data;
                r_filled <= 1'b1;
            end
            if (i_deq) r_filled <= 1'b0;
        end
    end

    assign o_pc     = r_pc;
    assign o_instr  = r_instr;
    assign o_filled = r_filled;
endmodule

module if_fetch_unit #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_instr
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [XLEN-1:0] r_pc;
    logic [PW-1:0]   r_head, r_tail, r_fptr;
    logic [CW-1:0]   r_occ, r_pend, r_disc;

    logic [DEPTH-1:0][XLEN-1:0] w_ent_pc, w_ent_instr;
    logic [DEPTH-1:0]           w_ent_filled;
    logic [CW:0]                w_inflight;
    logic w_acc, w_deq, w_fill, w_drop, w_rsp_hit;
    logic w_unused_ok;

    assign w_unused_ok = &{1'b0, redirect_pc[1:0]};

    // Every accepted request holds either a queue slot or a discard credit.
    assign w_inflight     = {1'b0, r_occ} + {1'b0, r_disc};
    assign imem_req_valid = !rst && (w_inflight < (CW+1)'(DEPTH));
    assign imem_req_addr  = r_pc;

    assign w_acc     = imem_req_valid && imem_req_ready;
    assign w_deq     = id_valid && id_ready;
    assign w_drop    = imem_rsp_valid && (r_disc != '0);
    assign w_fill    = imem_rsp_valid && (r_disc == '0) && (r_pend != '0) && !redirect_valid;
    assign w_rsp_hit = imem_rsp_valid && ((r_disc != '0) || (r_pend != '0));

    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_ent
            if_fetch_entry #(.XLEN(XLEN)) u_ent (
                .clk        (clk),
                .rst        (rst),
                .i_flush    (redirect_valid),
                .i_alloc    (w_acc && (r_tail == PW'(i))),
                .i_alloc_pc (r_pc),
                .i_fill     (w_fill && (r_fptr == PW'(i))),
                .i_fill_data(imem_rsp_data),
                .i_deq      (w_deq && (r_head == PW'(i))),
                .o_pc       (w_ent_pc[i]),
                .o_instr    (w_ent_instr[i]),
                .o_filled   (w_ent_filled[i])
            );
        end
    endgenerate

    assign id_valid = (r_occ != '0) && w_ent_filled[r_head];
    assign id_pc    = id_valid ? w_ent_pc[r_head]    : '0;
    assign id_instr = id_valid ? w_ent_instr[r_head] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc   <= RESET_PC;
            r_head <= '0;
            r_tail <= '0;
            r_fptr <= '0;
            r_occ  <= '0;
            r_pend <= '0;
            r_disc <= '0;
        end else if (redirect_valid) begin
            // Outstanding responses (pending, plus this cycle's accept, minus
            // this cycle's arrival) all become discard credits.
            r_pc   <= {redirect_pc[XLEN-1:2], 2'b00};
            r_head <= '0;
            r_tail <= '0;
            r_fptr <= '0;
            r_occ  <= '0;
            r_pend <= '0;
            r_disc <= r_disc + r_pend + CW'(w_acc) - CW'(w_rsp_hit);
        end else begin
            if (w_acc) r_pc <= r_pc + XLEN'(4);
            r_tail <= r_tail + PW'(w_acc);
            r_head <= r_head + PW'(w_deq);
            r_fptr <= r_fptr + PW'(w_fill);
            r_occ  <= r_occ + CW'(w_acc) - CW'(w_deq);
            r_pend <= r_pend + CW'(w_acc) - CW'(w_fill);
            r_disc <= r_disc - CW'(w_drop);
        end
    end
endmodule

// File: tb/tb_if_fetch_unit.sv
// Randomised scoreboard bench for if_fetch_unit with an in-order variable-latency
// memory model and a PC/epoch reference model.

module tb_if_fetch_unit;
    localparam int          XLEN     = 32;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk = 1'b0;
    logic        rst, redirect_valid, imem_req_ready, imem_rsp_valid, id_ready;
    logic [31:0] redirect_pc, imem_rsp_data;
    logic        imem_req_valid, id_valid;
    logic [31:0] imem_req_addr, id_pc, id_instr;

    if_fetch_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc), .id_instr(id_instr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory model: in-order responses, word = 0x13 + addr.
    typedef struct {
        logic [31:0] addr;
        int          due;
        int          epoch;
    } mreq_t;

    mreq_t       memq[$];
    logic [31:0] expq[$];
    int          cyc = 0;
    int          last_due = 0;
    int          lat_min = 1;
    int          lat_max = 1;

    always @(posedge clk) begin
        cyc++;
        #1;
        if (memq.size() > 0 && memq[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = 32'h13 + memq[0].addr;
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
    end

    // Reference model: M = responses still owed by memory, F = fetched words
    // waiting for ID; epoch marks requests made stale by a redirect.
    logic [31:0] model_pc = RESET_PC;
    int          M = 0;
    int          F = 0;
    int          epoch = 0;

    always @(negedge clk) begin
        if (rst) begin
            chk("req_valid_in_reset", {31'b0, imem_req_valid}, 32'd0);
            memq.delete();
            expq.delete();
            M = 0;
            F = 0;
            epoch++;
            model_pc = RESET_PC;
            last_due = cyc;
        end else begin
            chk("req_valid", {31'b0, imem_req_valid}, {31'b0, (M + F) < DEPTH});
            chk("id_valid",  {31'b0, id_valid},       {31'b0, F > 0});
            if (!id_valid) begin
                chk("id_pc_idle",    id_pc,    32'd0);
                chk("id_instr_idle", id_instr, 32'd0);
            end
            if (id_valid && id_ready) begin
                if (expq.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL id_deliver: got pc %h expected no instruction", id_pc);
                end else begin
                    logic [31:0] e;
                    e = expq.pop_front();
                    chk("id_pc",    id_pc,    e);
                    chk("id_instr", id_instr, 32'h13 + e);
                end
                if (F > 0) F--;
            end
            if (imem_rsp_valid && memq.size() > 0) begin
                mreq_t m;
                m = memq.pop_front();
                M--;
                if (m.epoch == epoch && !redirect_valid) F++;
            end
            if (imem_req_valid && imem_req_ready) begin
                int d;
                chk("req_addr", imem_req_addr, model_pc);
                d = cyc + $urandom_range(lat_min, lat_max);
                if (d <= last_due) d = last_due + 1;
                last_due = d;
                memq.push_back('{addr: imem_req_addr, due: d, epoch: epoch});
                expq.push_back(model_pc);
                M++;
                model_pc = model_pc + 32'd4;
            end
            if (redirect_valid) begin
                epoch++;
                F = 0;
                expq.delete();
                model_pc = {redirect_pc[31:2], 2'b00};
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic redirect(input logic [31:0] tgt);
        redirect_valid = 1'b1;
        redirect_pc    = tgt;
        tick();
        redirect_valid = 1'b0;
    endtask

    initial begin
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_req_ready = 1'b1;
        id_ready       = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(12);

        // Backpressure from ID fills the queue, then drains.
        id_ready = 1'b0;
        tick(10);
        id_ready = 1'b1;
        tick(10);

        // Redirect with slow memory and requests in flight.
        lat_min = 3; lat_max = 3;
        tick(4);
        redirect(32'h100);
        tick(12);

        lat_min = 1; lat_max = 1;
        redirect(32'h203);
        chk("redirect_align", imem_req_addr, 32'h200);
        tick(6);

        redirect(32'hFFFF_FFFC);
        tick(8);

        // Reset while the queue is full and responses are outstanding.
        id_ready = 1'b0;
        lat_min = 3; lat_max = 3;
        tick(8);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_addr",     imem_req_addr,      RESET_PC);
        chk("rst_id_valid", {31'b0, id_valid},  32'd0);
        id_ready = 1'b1;
        tick(10);

        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) begin
                lat_min = $urandom_range(1, 2);
                lat_max = lat_min + $urandom_range(0, 3);
            end
            imem_req_ready = ($urandom_range(0, 3) != 0);
            id_ready       = ($urandom_range(0, 2) != 0);
            redirect_valid = !redirect_valid && ($urandom_range(0, 15) == 0);
            redirect_pc    = $urandom;
            rst            = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst            = 1'b0;
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        id_ready       = 1'b1;
        tick(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
